// File: rtl/add_share_if.sv
// add_share_if: bundle between the four clients and the shared-adder arbiter.
//   req       : per-requester request (client -> arbiter)
//   a_bus     : operand A, requester i on [i*N +: N] (client -> arbiter)
//   b_bus     : operand B, same packing (client -> arbiter)
//   gnt       : one-hot grant pulse (arbiter -> client)
//   rsp_valid : result valid pulse (arbiter -> client)
//   rsp_id    : owner of the current result (arbiter -> client)
//   sum_out   : registered sum (arbiter -> client)
//   cout_out  : registered carry-out (arbiter -> client)
interface add_share_if #(parameter int N = 8);
  logic [3:0]     req;
  logic [4*N-1:0] a_bus;
  logic [4*N-1:0] b_bus;
  logic [3:0]     gnt;
  logic           rsp_valid;
  logic [1:0]     rsp_id;
  logic [N-1:0]   sum_out;
  logic           cout_out;

  modport master (output req, a_bus, b_bus,
                  input  gnt, rsp_valid, rsp_id, sum_out, cout_out);
  modport slave  (input  req, a_bus, b_bus,
                  output gnt, rsp_valid, rsp_id, sum_out, cout_out);
endinterface

// File: rtl/add_share_arbiter.sv
// add_share_arbiter: round-robin arbiter sharing one N-bit ripple-carry adder
// among four requesters. A grant latches the winner's operands; the next cycle
// the sum/carry are registered and returned with the winner's ID.
//   clk : clock, rising edge
//   rst : synchronous active-high reset
//   bus : add_share_if.slave (req/a_bus/b_bus in; gnt/rsp_* /sum_out/cout_out out)
// Optional: define ADD_SHARE_SAT_EN to saturate sum_out to all ones on carry-out
// (cout_out still reports the raw carry).

module add_share_fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module add_share_arbiter #(
  parameter int N = 8
) (
  input  logic        clk,
  input  logic        rst,
  add_share_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

  state_t       state_q, state_d;
  logic [N-1:0] opa_q, opa_d, opb_q, opb_d;
  logic [1:0]   win_q, win_d, ptr_q, ptr_d;
  logic [3:0]   gnt_q, gnt_d;
  logic         vld_q, vld_d;
  logic [1:0]   id_q, id_d;
  logic [N-1:0] sum_q, sum_d;
  logic         cout_q, cout_d;

  // unpack per-requester operand slices
  logic [N-1:0] a_sl [4];
  logic [N-1:0] b_sl [4];
  for (genvar i = 0; i < 4; i++) begin : g_sl
    assign a_sl[i] = bus.a_bus[i*N +: N];
    assign b_sl[i] = bus.b_bus[i*N +: N];
  end

  // shared ripple-carry adder, carry-in tied low
  logic [N:0]   c;
  logic [N-1:0] sum_w;
  assign c[0] = 1'b0;
  for (genvar i = 0; i < N; i++) begin : g_fa
    add_share_fa u_fa (
      .a (opa_q[i]),
      .b (opb_q[i]),
      .ci(c[i]),
      .s (sum_w[i]),
      .co(c[i+1])
    );
  end

  // round-robin pick: scan from ptr upward; iterate the offsets downward so
  // the nearest requester is the last (winning) assignment
  logic [1:0] win_w, idx;
  always_comb begin
    win_w = ptr_q;
    idx   = ptr_q;
    for (int k = 3; k >= 0; k--) begin
      idx = ptr_q + 2'(k);
      if (bus.req[idx]) win_w = idx;
    end
  end

  always_comb begin
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    win_d   = win_q;
    ptr_d   = ptr_q;
    gnt_d   = '0;
    vld_d   = 1'b0;
    id_d    = id_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    case (state_q)
      IDLE, RESP: begin
        if (|bus.req) begin
          gnt_d   = 4'b0001 << win_w;
          win_d   = win_w;
          opa_d   = a_sl[win_w];
          opb_d   = b_sl[win_w];
          ptr_d   = win_w + 2'd1;
          state_d = CALC;
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
`ifdef ADD_SHARE_SAT_EN
        sum_d   = c[N] ? '1 : sum_w;
`else
        sum_d   = sum_w;
`endif
        cout_d  = c[N];
        id_d    = win_q;
        vld_d   = 1'b1;
        state_d = RESP;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      win_q   <= '0;
      ptr_q   <= '0;
      gnt_q   <= '0;
      vld_q   <= 1'b0;
      id_q    <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      win_q   <= win_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      vld_q   <= vld_d;
      id_q    <= id_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.rsp_valid = vld_q;
  assign bus.rsp_id    = id_q;
  assign bus.sum_out   = sum_q;
  assign bus.cout_out  = cout_q;
endmodule

// File: tb/tb_add_share_arbiter.sv
module tb_add_share_arbiter;
  localparam int N = 8;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  logic [1:0] ref_ptr;
  logic [7:0] last_sum;
  logic       last_cout;

  add_share_if #(.N(N)) bus ();
  add_share_arbiter #(.N(N)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // reference: first requesting index from p upward, modulo 4
  function automatic logic [1:0] pick(input logic [3:0] r, input logic [1:0] p);
    for (int k = 0; k < 4; k++)
      if (r[(int'(p) + k) % 4]) return 2'((int'(p) + k) % 4);
    return p;
  endfunction

  // Called at a negedge with the DUT in IDLE or RESP and operands already on
  // the buses. Checks the grant cycle and then the response cycle.
  task automatic grant_cycle(input logic [3:0] r);
    logic [1:0] w;
    logic [8:0] full;
    logic [7:0] es;
    bus.req = r;
    w       = pick(r, ref_ptr);
    full    = {1'b0, bus.a_bus[int'(w)*8 +: 8]} + {1'b0, bus.b_bus[int'(w)*8 +: 8]};
    es      = full[7:0];
`ifdef ADD_SHARE_SAT_EN
    if (full[8]) es = 8'hFF;
`endif
    ref_ptr = w + 2'd1;
    @(negedge clk);
    check("gnt", 32'(bus.gnt), 32'(4'(4'b0001 << w)));
    check("rsp_valid_in_gnt", 32'(bus.rsp_valid), 32'd0);
    // granted requester drops its request; operand changes must be ignored
    bus.req   = r & ~(4'(4'b0001 << w));
    bus.a_bus = $urandom;
    bus.b_bus = $urandom;
    @(negedge clk);
    check("rsp_valid", 32'(bus.rsp_valid), 32'd1);
    check("gnt_in_rsp", 32'(bus.gnt), 32'd0);
    check("rsp_id", 32'(bus.rsp_id), 32'(w));
    check("sum_out", 32'(bus.sum_out), 32'(es));
    check("cout_out", 32'(bus.cout_out), 32'(full[8]));
    last_sum  = es;
    last_cout = full[8];
  endtask

  task automatic idle_cycle();
    bus.req = 4'h0;
    @(negedge clk);
    check("idle_gnt", 32'(bus.gnt), 32'd0);
    check("idle_valid", 32'(bus.rsp_valid), 32'd0);
    check("hold_sum", 32'(bus.sum_out), 32'(last_sum));
    check("hold_cout", 32'(bus.cout_out), 32'(last_cout));
  endtask

  initial begin
    rst       = 1'b1;
    bus.req   = 4'hF;
    bus.a_bus = $urandom;
    bus.b_bus = $urandom;
    ref_ptr   = 2'd0;
    last_sum  = 8'h00;
    last_cout = 1'b0;

    // reset held two cycles with all requests high
    repeat (2) begin
      @(negedge clk);
      check("rst_gnt", 32'(bus.gnt), 32'd0);
      check("rst_valid", 32'(bus.rsp_valid), 32'd0);
      check("rst_sum", 32'(bus.sum_out), 32'd0);
      check("rst_cout", 32'(bus.cout_out), 32'd0);
      check("rst_id", 32'(bus.rsp_id), 32'd0);
    end
    rst = 1'b0;

    // round robin with all requesters re-raising: 0,1,2,3,0
    for (int i = 0; i < 5; i++) begin
      bus.a_bus = $urandom;
      bus.b_bus = $urandom;
      grant_cycle(4'hF);
    end
    idle_cycle();

    // single request, requester 2: 0x12 + 0x34
    bus.a_bus = 32'h0012_0000;
    bus.b_bus = 32'h0034_0000;
    grant_cycle(4'b0100);
    check("single_sum", 32'(bus.sum_out), 32'h46);
    idle_cycle();

    // overflow wrap on requester 0
    bus.a_bus = 32'h0000_00FF;
    bus.b_bus = 32'h0000_0001;
    grant_cycle(4'b0001);
    check("ovf_cout", 32'(bus.cout_out), 32'd1);
    idle_cycle();

    // ptr wrap: grant to 3, then 1001 -> 0 then 3
    bus.a_bus = $urandom; bus.b_bus = $urandom;
    grant_cycle(4'b1000);
    bus.a_bus = $urandom; bus.b_bus = $urandom;
    grant_cycle(4'b1001);
    check("wrap_id0", 32'(bus.rsp_id), 32'd0);
    bus.a_bus = $urandom; bus.b_bus = $urandom;
    grant_cycle(4'b1001);
    check("wrap_id3", 32'(bus.rsp_id), 32'd3);
    idle_cycle();

    // reset during CALC discards the result
    bus.a_bus = $urandom; bus.b_bus = $urandom;
    bus.req   = 4'b0001;
    @(negedge clk);
    check("pre_rst_gnt", 32'(bus.gnt), 32'(pick(4'b0001, ref_ptr) == 2'd0 ? 4'b0001 : 4'b0000));
    rst     = 1'b1;
    bus.req = 4'b0010;
    @(negedge clk);
    check("midrst_valid", 32'(bus.rsp_valid), 32'd0);
    check("midrst_gnt", 32'(bus.gnt), 32'd0);
    check("midrst_sum", 32'(bus.sum_out), 32'd0);
    check("midrst_cout", 32'(bus.cout_out), 32'd0);
    check("midrst_id", 32'(bus.rsp_id), 32'd0);
    rst       = 1'b0;
    ref_ptr   = 2'd0;
    last_sum  = 8'h00;
    last_cout = 1'b0;
    grant_cycle(4'b0010);

    // randomized traffic against the reference model
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 3) == 0) idle_cycle();
      bus.a_bus = $urandom;
      bus.b_bus = $urandom;
      grant_cycle(4'($urandom_range(1, 15)));
    end
    idle_cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
